// File: rtl/timer_sequencer_if.sv
// Configuration, control and strobe bundle between a register/CPU master and
// the timer_sequencer datapath.
interface timer_sequencer_if #(
  parameter int WIDTH  = 16,
  parameter int PWIDTH = 8,
  parameter int CWIDTH = 8
);
  logic              cfg_vld;
  logic              cfg_rdy;
  logic [PWIDTH-1:0] cfg_pre;
  logic [WIDTH-1:0]  cfg_max;
  logic [CWIDTH-1:0] cfg_rep;
  logic              start;
  logic              stop;
  logic              busy;
  logic              tck;
  logic [WIDTH-1:0]  cnt;
  logic              pls;
  logic              done;
  logic              irq;
  logic              irq_clr;

  modport master (
    output cfg_vld, cfg_pre, cfg_max, cfg_rep, start, stop, irq_clr,
    input  cfg_rdy, busy, tck, cnt, pls, done, irq
  );

  modport slave (
    input  cfg_vld, cfg_pre, cfg_max, cfg_rep, start, stop, irq_clr,
    output cfg_rdy, busy, tck, cnt, pls, done, irq
  );
endinterface

// File: rtl/timer_sequencer.sv
// Prescaler plus wrap-on-max period counter, run as one-shot / N-repeat /
// free-running sessions by an IDLE/RUN FSM, with a sticky completion interrupt.
module timer_sequencer #(
  parameter int WIDTH  = 16,
  parameter int PWIDTH = 8,
  parameter int CWIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  timer_sequencer_if.slave   tif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PWIDTH-1:0] pre_q, pre_d;
  logic [WIDTH-1:0]  max_q, max_d;
  logic [CWIDTH-1:0] rep_q, rep_d;
  logic [PWIDTH-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [CWIDTH-1:0] rcnt_q, rcnt_d;
  logic              irq_q, irq_d;

  logic run;
  logic cfg_acc;
  logic tck;
  logic pls;
  logic last;
  logic done;

  // Strobes come straight from registered state so they are glitch-free
  // single-cycle pulses aligned with the counter values they describe.
  assign run     = (state_q == S_RUN);
  assign cfg_acc = tif.cfg_vld & ~run;
  assign tck     = run & (pcnt_q == pre_q);
  assign pls     = tck & (cnt_q == max_q);
  assign last    = (rep_q != '0) & (rcnt_q == rep_q - CWIDTH'(1));
  assign done    = pls & last;

  assign tif.cfg_rdy = ~run;
  assign tif.busy    = run;
  assign tif.tck     = tck;
  assign tif.cnt     = cnt_q;
  assign tif.pls     = pls;
  assign tif.done    = done;
  assign tif.irq     = irq_q;

  always_comb begin
    // NOTE: every next-state signal gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pre_d   = pre_q;
    max_d   = max_q;
    rep_d   = rep_q;
    pcnt_d  = pcnt_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    irq_d   = irq_q;

    // Loading here lets a cfg_vld coinciding with start govern that session.
    if (cfg_acc) begin
      pre_d = tif.cfg_pre;
      max_d = tif.cfg_max;
      rep_d = tif.cfg_rep;
    end

    unique case (state_q)
      S_IDLE: begin
        if (tif.start) begin
          state_d = S_RUN;
          pcnt_d  = '0;
          cnt_d   = '0;
          rcnt_d  = '0;
        end
      end
      S_RUN: begin
        if (done || tif.stop) begin
          state_d = S_IDLE;
          pcnt_d  = '0;
          cnt_d   = '0;
          rcnt_d  = '0;
        end else if (tif.start) begin
          pcnt_d = '0;
          cnt_d  = '0;
          rcnt_d = '0;
        end else begin
          pcnt_d = tck ? '0 : pcnt_q + PWIDTH'(1);
          if (tck) cnt_d = pls ? '0 : cnt_q + WIDTH'(1);
          if (pls) rcnt_d = rcnt_q + CWIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Completion beats a simultaneous clear so an interrupt is never lost.
    if (done)             irq_d = 1'b1;
    else if (tif.irq_clr) irq_d = 1'b0;
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      max_q   <= '0;
      rep_q   <= '0;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      max_q   <= max_d;
      rep_q   <= rep_d;
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer: a per-cycle vector table for one full
// session, then hand-written sequences for the multi-cycle corner cases.
module tb_timer_sequencer;

  localparam int WIDTH  = 16;
  localparam int PWIDTH = 8;
  localparam int CWIDTH = 8;

  logic clk;
  logic rst_n;

  timer_sequencer_if #(.WIDTH(WIDTH), .PWIDTH(PWIDTH), .CWIDTH(CWIDTH)) tif ();

  timer_sequencer #(.WIDTH(WIDTH), .PWIDTH(PWIDTH), .CWIDTH(CWIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tif   (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        start;
    logic        stop;
    logic        vld;
    logic        clr;
    logic        rdy;
    logic        busy;
    logic        tck;
    logic        pls;
    logic        done;
    logic        irq;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic st, sp, vl, cl, rdy, busy, tck, pls, done, irq,
                              input logic [15:0] cnt);
    vec_t v;
    v.start = st; v.stop = sp; v.vld = vl; v.clr = cl;
    v.rdy = rdy; v.busy = busy; v.tck = tck; v.pls = pls; v.done = done; v.irq = irq;
    v.cnt = cnt;
    return v;
  endfunction

  task automatic set_cfg(input logic [PWIDTH-1:0] p, input logic [WIDTH-1:0] m,
                         input logic [CWIDTH-1:0] r);
    tif.cfg_pre = p;
    tif.cfg_max = m;
    tif.cfg_rep = r;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n       = 1'b0;
    tif.cfg_vld = 1'b0;
    tif.start   = 1'b0;
    tif.stop    = 1'b0;
    tif.irq_clr = 1'b0;
    set_cfg('0, '0, '0);

    // Session pre=1 max=2 rep=2: period 6, pls at E0+5 and E0+11.
    //            st sp vl cl rdy bsy tck pls dn irq cnt
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)); // E0
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 2)); // E0+5
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 2)); // E0+11
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0)); // E0+12, clear irq
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    // Reset state
    cyc();
    cyc();
    check("rst_rdy",  tif.cfg_rdy, 1);
    check("rst_busy", tif.busy, 0);
    check("rst_tck",  tif.tck, 0);
    check("rst_cnt",  tif.cnt, 0);
    check("rst_pls",  tif.pls, 0);
    check("rst_done", tif.done, 0);
    check("rst_irq",  tif.irq, 0);
    rst_n = 1'b1;
    cyc();

    // Table-driven full session
    set_cfg(8'd1, 16'd2, 8'd2);
    for (int i = 0; i < vecs.size(); i++) begin
      tif.start   = vecs[i].start;
      tif.stop    = vecs[i].stop;
      tif.cfg_vld = vecs[i].vld;
      tif.irq_clr = vecs[i].clr;
      #1;
      check($sformatf("vec%0d{rdy,busy,tck,pls,done,irq,cnt}", i),
            {10'd0, tif.cfg_rdy, tif.busy, tif.tck, tif.pls, tif.done, tif.irq, tif.cnt},
            {10'd0, vecs[i].rdy, vecs[i].busy, vecs[i].tck, vecs[i].pls, vecs[i].done,
             vecs[i].irq, vecs[i].cnt});
      cyc();
    end
    tif.start = 0; tif.stop = 0; tif.cfg_vld = 0; tif.irq_clr = 0;

    // Free-running pre=0 max=0: tck=pls every cycle, never done; then stop
    set_cfg(8'd0, 16'd0, 8'd0);
    tif.cfg_vld = 1; tif.start = 1;
    cyc();
    tif.cfg_vld = 0; tif.start = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("free%0d{busy,tck,pls,done,cnt}", i),
            {tif.busy, tif.tck, tif.pls, tif.done, tif.cnt}, {4'b1110, 16'd0});
      cyc();
    end
    tif.stop = 1;
    cyc();
    tif.stop = 0;
    check("stop_busy", tif.busy, 0);
    check("stop_cnt",  tif.cnt, 0);
    check("stop_irq",  tif.irq, 0);
    tif.stop = 1;
    cyc();
    check("idle_stop_ignored", tif.busy, 0);
    tif.start = 1;
    cyc();
    tif.start = 0;
    check("idle_start_stop_runs", tif.busy, 1);
    cyc();
    tif.stop = 0;
    check("stop_again_idle", tif.busy, 0);

    // pre=3 max=4 rep=1: stop coincident with final pls still completes
    set_cfg(8'd3, 16'd4, 8'd1);
    tif.cfg_vld = 1;
    cyc();
    tif.cfg_vld = 0; tif.start = 1;
    cyc();
    tif.start = 0;
    repeat (19) cyc();
    tif.stop = 1;
    #1;
    check("stop_final_pls", tif.pls, 1);
    check("stop_final_done", tif.done, 1);
    cyc();
    tif.stop = 0;
    check("stop_final_busy", tif.busy, 0);
    check("stop_final_irq", tif.irq, 1);

    // Restart at E0+7 moves the pls to E0+27
    tif.start = 1;
    cyc();
    tif.start = 0;
    repeat (7) cyc();
    tif.start = 1;
    cyc();
    tif.start = 0;
    n = 8;
    #1;
    while (!tif.pls && n < 60) begin
      cyc();
      #1;
      n++;
    end
    check("restart_pls_cycle", n, 27);
    check("restart_done", tif.done, 1);
    tif.irq_clr = 1;
    cyc();
    tif.irq_clr = 0;
    check("clr_vs_done_irq", tif.irq, 1);
    check("restart_busy_low", tif.busy, 0);
    tif.irq_clr = 1;
    cyc();
    tif.irq_clr = 0;
    check("irq_clr", tif.irq, 0);

    // Config while busy is refused; cfg_vld with start in IDLE is bypassed
    set_cfg(8'd1, 16'd1, 8'd1);
    tif.cfg_vld = 1;
    cyc();
    tif.cfg_vld = 0; tif.start = 1;
    cyc();
    tif.start = 0;
    cyc();
    set_cfg(8'd5, 16'd5, 8'd3);
    tif.cfg_vld = 1;
    #1;
    check("busy_cfg_rdy", tif.cfg_rdy, 0);
    cyc();
    tif.cfg_vld = 0;
    cyc();
    check("busy_cfg_ignored{pls,done}", {tif.pls, tif.done}, 2'b11);
    cyc();
    check("busy_cfg_end", tif.busy, 0);
    set_cfg(8'd2, 16'd0, 8'd1);
    tif.cfg_vld = 1; tif.start = 1;
    cyc();
    tif.cfg_vld = 0; tif.start = 0;
    check("bypass_e0_tck", tif.tck, 0);
    cyc();
    cyc();
    check("bypass{tck,pls,done}", {tif.tck, tif.pls, tif.done}, 3'b111);
    cyc();
    check("bypass_irq", tif.irq, 1);

    // Reset mid-run with cnt=3 and irq=1
    set_cfg(8'd0, 16'd9, 8'd0);
    tif.cfg_vld = 1; tif.start = 1;
    cyc();
    tif.cfg_vld = 0; tif.start = 0;
    repeat (3) cyc();
    check("pre_reset_cnt", tif.cnt, 3);
    rst_n = 1'b0;
    #1;
    check("mid_reset{rdy,busy,tck,pls,done,irq}",
          {tif.cfg_rdy, tif.busy, tif.tck, tif.pls, tif.done, tif.irq}, 6'b100000);
    check("mid_reset_cnt", tif.cnt, 0);
    cyc();
    rst_n = 1'b1;
    #1;
    check("post_reset_rdy", tif.cfg_rdy, 1);
    tif.start = 1;
    cyc();
    tif.start = 0;
    check("zero_cfg0{busy,tck,pls,cnt}", {tif.busy, tif.tck, tif.pls, tif.cnt}, {3'b111, 16'd0});
    cyc();
    check("zero_cfg1{busy,tck,pls,cnt}", {tif.busy, tif.tck, tif.pls, tif.cnt}, {3'b111, 16'd0});
    tif.stop = 1;
    cyc();
    tif.stop = 0;
    check("final_idle", tif.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_sequencer.md
# timer_sequencer

Programmable timer controller that sequences a prescaler and a wrap-on-maximum period counter. It runs them through one-shot, N-repeat or free-running sessions under a start/stop FSM. Configuration uses a valid/ready handshake, and completion raises a sticky interrupt. It sits between a register/CPU interface and the timing datapath, and generates periodic strobes for downstream blocks.

## Interface
- WIDTH, 16, period counter width
- PWIDTH, 8, prescaler counter width
- CWIDTH, 8, repeat counter width
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- cfg_vld  input  1  configuration valid
- cfg_rdy  output  1  configuration ready; high only in IDLE
- cfg_pre  input  PWIDTH  prescaler maximum (tick every cfg_pre+1 cycles)
- cfg_max  input  WIDTH  period counter maximum (wrap after cfg_max+1 ticks)
- cfg_rep  input  CWIDTH  period count per session; 0 = free-running
- start  input  1  start/restart request
- stop  input  1  abort request
- busy  output  1  high in RUN
- tck  output  1  prescaler wrap strobe
- cnt  output  WIDTH  period counter value
- pls  output  1  period wrap strobe
- done  output  1  session-complete strobe
- irq  output  1  sticky completion flag
- irq_clr  input  1  clears irq

## Operation
- The FSM has two states: IDLE and RUN. Reset enters IDLE.
- Shadow registers pre, max and rep load on cfg_vld & cfg_rdy. Reset values are all zero.
- Internal counters:
  - pcnt (PWIDTH) is the prescaler.
  - cnt (WIDTH) is the period counter.
  - rcnt (CWIDTH) counts completed periods.
- All counters clear on entry to RUN, on restart, and on return to IDLE.
- IDLE & start -> RUN.
  - If cfg_vld is high in the same cycle, the new configuration is accepted and used by this session (bypass).
- In RUN:
  - pcnt increments every cycle and wraps to 0 when pcnt == pre.
  - tck = RUN & (pcnt == pre).
  - cnt increments on tck and wraps to 0 when cnt == max.
  - pls = tck & (cnt == max).
  - rcnt increments on pls.
  - last = (rep != 0) & (rcnt == rep-1).
  - done = pls & last. Next state is IDLE and irq sets.
  - RUN & start (no final pls): restart. Counters clear and the FSM stays in RUN. Configuration is not reloaded.
  - RUN & stop: next state is IDLE, counters clear, no done, irq unchanged.
- Priority within a RUN cycle: done > stop > start.
  - When the final pls coincides with stop or start, the session completes normally: done=1, irq sets, next state is IDLE.
- In IDLE, stop is ignored. start and stop together in IDLE: stop is ignored and RUN is entered.
- irq: set wins over irq_clr in the same cycle. irq_clr with no set clears it next cycle.
- All arithmetic is unsigned modulo field width. pre=0 means tck every RUN cycle. max=0 means pls on every tck.

## Timing
- Reset values: cfg_rdy=1, busy=0, tck=0, cnt=0, pls=0, done=0, irq=0.
- cfg_rdy = !busy (combinational from state).
- tck, pls and done are combinational from registered state. Each is a single-cycle strobe.
- start sampled at edge E0 puts the FSM in RUN with pcnt=0 during cycle E0.
  - First tck is in cycle E0+pre.
  - The k-th pls is in cycle E0 + k*(pre+1)*(max+1) - 1.
- busy, cnt and irq are registered. irq rises the cycle after done.
- busy falls the cycle after done or stop.
- A session with rep=R lasts exactly R*(pre+1)*(max+1) cycles of busy.
- Restart latency is 0: the cycle after a restart edge behaves as cycle E0.
- Asserting reset mid-session forces IDLE and all outputs to their reset values immediately. No done is issued.

## Test plan
- Configure pre=1, max=2, rep=2, then start -> pls in cycles E0+5 and E0+11, done with the second pls, busy low from E0+12, irq=1 from E0+12.
- Configure pre=0, max=0, rep=0, then start -> tck=pls=1 every cycle, done never asserted. stop -> busy=0 next cycle, cnt=0, irq stays 0.
- Running with pre=3, max=4, rep=1, assert stop together with the final pls (E0+19) -> done=1, irq sets, and IDLE is entered. Assert start mid-period at E0+7 instead -> next pls moves to E0+27.
- While busy, pulse cfg_vld with new values -> cfg_rdy=0, values not taken. In IDLE, cfg_vld & start in the same cycle -> the new pre/max govern the session.
- With irq=1, pulse irq_clr -> irq=0 next cycle. irq_clr coincident with done -> irq remains 1.
- Assert reset for one cycle mid-RUN (cnt=3) -> busy=0, cnt=0 and irq=0 immediately. After reset release, cfg_rdy=1 and the shadow config reads as zero (pre=0, max=0).
